// File: rtl/bp_serial_packet_link.sv
// Multi-channel packet link: round-robin TX serializer sending LSB-first flits
// with a channel-id sideband, and an RX reassembler with one slot per channel.
module bp_serial_packet_link #(
  parameter int data_width_p  = 64,
  parameter int link_width_p  = 16,
  parameter int els_p         = 4,
  localparam int num_flits_lp = (data_width_p + link_width_p - 1) / link_width_p,
  localparam int id_width_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [els_p-1:0]                     valid_i,
  input  logic [els_p-1:0][data_width_p-1:0]   data_i,
  output logic [els_p-1:0]                     yumi_o,
  output logic                                 link_v_o,
  output logic [link_width_p-1:0]              link_data_o,
  output logic [id_width_lp-1:0]               link_id_o,
  output logic                                 link_last_o,
  input  logic                                 link_ready_i,
  input  logic                                 link_v_i,
  input  logic [link_width_p-1:0]              link_data_i,
  input  logic [id_width_lp-1:0]               link_id_i,
  output logic                                 link_ready_o,
  output logic [els_p-1:0]                     valid_o,
  output logic [els_p-1:0][data_width_p-1:0]   data_o,
  input  logic [els_p-1:0]                     yumi_i
);

  localparam int cnt_width_lp = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1;
  localparam int pad_width_lp = num_flits_lp * link_width_p;

  typedef logic [id_width_lp-1:0]  id_t;
  typedef logic [cnt_width_lp-1:0] cnt_t;
  typedef logic [pad_width_lp-1:0] pad_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  localparam cnt_t last_cnt_lp = cnt_t'(num_flits_lp - 1);

  // ---------------- TX ----------------
  tx_state_e tx_state_r, tx_state_n;
  id_t       rr_r, tx_id_r, grant_id;
  cnt_t      tx_cnt_r;
  pad_t      tx_data_r;
  logic      grant_v, tx_grant, tx_last, tx_fire;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_v  = 1'b0;
    grant_id = '0;
    for (int k = 1; k <= els_p; k++) begin
      if (!grant_v && valid_i[(int'(rr_r) + k) % els_p]) begin
        grant_v  = 1'b1;
        grant_id = id_t'((int'(rr_r) + k) % els_p);
      end
    end
  end

  assign tx_grant = (tx_state_r == TX_IDLE) && grant_v && !reset_i;
  assign tx_last  = (tx_cnt_r == last_cnt_lp);
  assign tx_fire  = (tx_state_r == TX_SEND) && link_ready_i;

  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_i) tx_state_r <= TX_IDLE;
    else         tx_state_r <= tx_state_n;
  end

  always_comb begin
    tx_state_n = tx_state_r;
    case (tx_state_r)
      TX_IDLE: if (tx_grant)           tx_state_n = TX_SEND;
      TX_SEND: if (tx_fire && tx_last) tx_state_n = TX_IDLE;
      default:                         tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    yumi_o      = '0;
    link_v_o    = 1'b0;
    link_data_o = '0;
    link_id_o   = '0;
    link_last_o = 1'b0;
    case (tx_state_r)
      TX_IDLE: if (tx_grant) yumi_o[grant_id] = 1'b1;
      TX_SEND: begin
        link_v_o    = 1'b1;
        link_data_o = tx_data_r[int'(tx_cnt_r)*link_width_p +: link_width_p];
        link_id_o   = tx_id_r;
        link_last_o = tx_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_r     <= id_t'(els_p - 1);
      tx_cnt_r <= '0;
    end else begin
      if (tx_grant) rr_r <= grant_id;
      if (tx_fire)  tx_cnt_r <= tx_last ? '0 : tx_cnt_r + cnt_t'(1);
    end
  end

  // NOTE: payload registers carry no reset; they are only observed once a valid/state bit qualifies them.
  // Zero-extension to the padded width is what zeroes the unused bits of the final flit.
  always_ff @(posedge clk_i) begin
    if (tx_grant) begin
      tx_id_r   <= grant_id;
      tx_data_r <= pad_t'(data_i[grant_id]);
    end
  end

  // ---------------- RX ----------------
  cnt_t                             rx_cnt_r;
  id_t                              rx_id_r, rid_eff;
  pad_t                             rx_asm_r, rx_asm_n;
  logic                             rx_last, rx_fire;
  logic [els_p-1:0]                 valid_r;
  logic [els_p-1:0][data_width_p-1:0] data_r;

  // With single-flit packets the id must come straight off the link.
  assign rid_eff      = (num_flits_lp == 1) ? link_id_i : rx_id_r;
  assign rx_last      = (rx_cnt_r == last_cnt_lp);
  assign link_ready_o = rx_last ? !valid_r[rid_eff] : 1'b1;
  assign rx_fire      = link_v_i && link_ready_o;

  always_comb begin
    rx_asm_n = rx_asm_r;
    rx_asm_n[int'(rx_cnt_r)*link_width_p +: link_width_p] = link_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_cnt_r <= '0;
      valid_r  <= '0;
    end else begin
      valid_r <= valid_r & ~yumi_i;
      if (rx_fire) begin
        if (rx_last) begin
          valid_r[rid_eff] <= 1'b1;
          rx_cnt_r         <= '0;
        end else begin
          rx_cnt_r <= rx_cnt_r + cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_fire) begin
      rx_asm_r <= rx_asm_n;
      if (rx_cnt_r == '0) rx_id_r <= link_id_i;
      if (rx_last)        data_r[rid_eff] <= rx_asm_n[data_width_p-1:0];
    end
  end

  assign valid_o = valid_r;
  assign data_o  = data_r;

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    (yumi_i & ~valid_r) == '0);

endmodule

// File: tb/tb_bp_serial_packet_link.sv
// Bench for bp_serial_packet_link: looped-back link, scoreboard of granted packets,
// plus two narrow-payload instances (40-bit and 8-bit) for flit-count corner cases.
module tb_bp_serial_packet_link;
  localparam int dw = 64, lw = 16, els = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                     reset_i, tb_ready;
  logic [els-1:0]           valid_i, yumi_o, valid_o, yumi_i;
  logic [els-1:0][dw-1:0]   data_i, data_o;
  logic                     link_v_o, link_last_o, link_ready_i, link_v_i, link_ready_o;
  logic [lw-1:0]            link_data_o, link_data_i;
  logic [1:0]               link_id_o, link_id_i;

  assign link_v_i     = link_v_o && tb_ready;
  assign link_ready_i = link_ready_o && tb_ready;
  assign link_data_i  = link_data_o;
  assign link_id_i    = link_id_o;

  bp_serial_packet_link #(.data_width_p(dw), .link_width_p(lw), .els_p(els)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i), .yumi_o(yumi_o),
    .link_v_o(link_v_o), .link_data_o(link_data_o), .link_id_o(link_id_o),
    .link_last_o(link_last_o), .link_ready_i(link_ready_i), .link_v_i(link_v_i),
    .link_data_i(link_data_i), .link_id_i(link_id_i), .link_ready_o(link_ready_o),
    .valid_o(valid_o), .data_o(data_o), .yumi_i(yumi_i));

  // 40-bit payload, 2 channels, plain loopback
  logic [1:0]        v40, y40, vo40, yi40;
  logic [1:0][39:0]  d40, do40;
  logic              l40_v, l40_last, l40_rdy;
  logic [15:0]       l40_data;
  logic [0:0]        l40_id;

  bp_serial_packet_link #(.data_width_p(40), .link_width_p(16), .els_p(2)) dut40 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(v40), .data_i(d40), .yumi_o(y40),
    .link_v_o(l40_v), .link_data_o(l40_data), .link_id_o(l40_id), .link_last_o(l40_last),
    .link_ready_i(l40_rdy), .link_v_i(l40_v), .link_data_i(l40_data), .link_id_i(l40_id),
    .link_ready_o(l40_rdy), .valid_o(vo40), .data_o(do40), .yumi_i(yi40));

  // 8-bit payload, single flit per packet
  logic [1:0]        v8, y8, vo8, yi8;
  logic [1:0][7:0]   d8, do8;
  logic              l8_v, l8_last, l8_rdy;
  logic [15:0]       l8_data;
  logic [0:0]        l8_id;

  bp_serial_packet_link #(.data_width_p(8), .link_width_p(16), .els_p(2)) dut8 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(v8), .data_i(d8), .yumi_o(y8),
    .link_v_o(l8_v), .link_data_o(l8_data), .link_id_o(l8_id), .link_last_o(l8_last),
    .link_ready_i(l8_rdy), .link_v_i(l8_v), .link_data_i(l8_data), .link_id_i(l8_id),
    .link_ready_o(l8_rdy), .valid_o(vo8), .data_o(do8), .yumi_i(yi8));

  typedef struct packed {
    logic [1:0]    id;
    logic [dw-1:0] data;
  } pkt_t;

  pkt_t exp_q[$];
  int   tests, fails;
  bit   auto_yumi;

  // Pop the oldest granted packet and compare against the RX slot of channel c.
  task automatic rx_take(input int c);
    pkt_t e;
    yumi_i[c] = 1'b1;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL rx_unexpected: ch%0d delivered %h, no packet expected", c, data_o[c]);
    end else begin
      e = exp_q.pop_front();
      if (int'(e.id) != c || data_o[c] !== e.data) begin
        fails++;
        $display("FAIL rx_data: got ch%0d %h, expected ch%0d %h", c, data_o[c], e.id, e.data);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    yumi_i = '0;
    if (auto_yumi)
      for (int c = 0; c < els; c++)
        if (valid_o[c]) rx_take(c);
  endtask

  // Offer one packet on channel c while TX is idle; returns with flit 0 on the link.
  task automatic send(input int c, input logic [dw-1:0] d);
    pkt_t           e;
    logic [els-1:0] oh;
    tick();
    data_i[c] = d;
    valid_i   = '0;
    valid_i[c] = 1'b1;
    oh = '0;
    oh[c] = 1'b1;
    #1;
    tests++;
    if (yumi_o !== oh) begin
      fails++;
      $display("FAIL send_yumi: yumi_o=%b, expected %b", yumi_o, oh);
    end
    e.id = 2'(c);
    e.data = d;
    exp_q.push_back(e);
    tick();
    valid_i = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || link_v_o) && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d packets outstanding, expected 0", exp_q.size());
    end
  endtask

  function automatic logic [dw-1:0] mk(input int c, input int k);
    return {16'hC000 | 16'(c), 16'(k), 32'hDEAD_BEEF ^ 32'(c * 7 + k)};
  endfunction

  task automatic test_reset();
    reset_i = 1'b1;
    valid_i = '1;
    repeat (2) tick();
    #1;
    tests++;
    if ({yumi_o, link_v_o, link_last_o, valid_o, link_ready_o} !== {4'b0, 1'b0, 1'b0, 4'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: yumi=%b v=%b last=%b valid_o=%b ready=%b, expected 0 0 0 0 1",
               yumi_o, link_v_o, link_last_o, valid_o, link_ready_o);
    end
    valid_i = '0;
    reset_i = 1'b0;
  endtask

  task automatic test_single();
    logic [dw-1:0] pkt = 64'h0123_4567_89AB_CDEF;
    send(2, pkt);
    for (int f = 0; f < 4; f++) begin
      if (f > 0) tick();
      tests++;
      if ({link_v_o, link_id_o, link_last_o, link_data_o, valid_o[2]} !==
          {1'b1, 2'd2, (f == 3), pkt[f*lw +: lw], 1'b0}) begin
        fails++;
        $display("FAIL single_flit%0d: v=%b id=%0d last=%b data=%h valid2=%b, expected 1 2 %0b %h 0",
                 f, link_v_o, link_id_o, link_last_o, link_data_o, valid_o[2], (f == 3), pkt[f*lw +: lw]);
      end
    end
    tick();
    tests++;
    if (valid_o[2] !== 1'b1 || link_v_o !== 1'b0) begin
      fails++;
      $display("FAIL single_valid_rise: valid2=%b link_v=%b, expected 1 0", valid_o[2], link_v_o);
    end
    tick();
    tests++;
    if (valid_o[2] !== 1'b0) begin
      fails++;
      $display("FAIL single_yumi_clear: valid2=%b, expected 0", valid_o[2]);
    end
  endtask

  task automatic test_round_robin();
    int             cnt [els];
    int             k = 0, pend = -1;
    logic [els-1:0] prev = '0, oh;
    pkt_t           e;
    reset_i = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    for (int c = 0; c < els; c++) begin
      cnt[c] = 0;
      data_i[c] = mk(c, 0);
    end
    reset_i = 1'b0;
    valid_i = '1;
    for (int cyc = 0; cyc < 60 && k < 5; cyc++) begin
      #1;
      if (prev != '0) begin
        tests++;
        if (yumi_o != '0) begin
          fails++;
          $display("FAIL rr_yumi_width: yumi_o=%b right after grant, expected 0", yumi_o);
        end
      end
      if (yumi_o != '0) begin
        oh = '0;
        oh[k % els] = 1'b1;
        tests++;
        if (!$onehot(yumi_o) || yumi_o !== oh) begin
          fails++;
          $display("FAIL rr_grant%0d: yumi_o=%b, expected %b", k, yumi_o, oh);
        end
        e.id = 2'(k % els);
        e.data = data_i[k % els];
        exp_q.push_back(e);
        pend = k % els;
        k++;
      end
      prev = yumi_o;
      tick();
      if (pend >= 0) begin
        cnt[pend]++;
        data_i[pend] = mk(pend, cnt[pend]);
        pend = -1;
      end
    end
    valid_i = '0;
    tests++;
    if (k < 5) begin
      fails++;
      $display("FAIL rr_timeout: %0d grants seen, expected 5", k);
    end
    drain(60);
  endtask

  task automatic test_stall();
    logic [dw-1:0] pkt = 64'hFEDC_BA98_7654_3210;
    logic          rp [12] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    int            f = 0;
    send(1, pkt);
    for (int i = 0; i < 12 && f < 4; i++) begin
      tb_ready = rp[i];
      tests++;
      if ({link_v_o, link_id_o, link_last_o, link_data_o} !== {1'b1, 2'd1, (f == 3), pkt[f*lw +: lw]}) begin
        fails++;
        $display("FAIL stall_hold%0d: v=%b id=%0d last=%b data=%h, expected 1 1 %0b %h",
                 i, link_v_o, link_id_o, link_last_o, link_data_o, (f == 3), pkt[f*lw +: lw]);
      end
      if (tb_ready) f++;
      tick();
    end
    tb_ready = 1'b1;
    tests++;
    if (f < 4) begin
      fails++;
      $display("FAIL stall_timeout: %0d flits sent, expected 4", f);
    end
    drain(20);
  endtask

  task automatic test_full_slot();
    logic [dw-1:0] pa = 64'hAAAA_0001_AAAA_0002;
    logic [dw-1:0] pb = 64'hBBBB_0003_BBBB_0004;
    auto_yumi = 1'b0;
    send(1, pa);
    for (int i = 0; i < 10 && valid_o[1] !== 1'b1; i++) tick();
    tests++;
    if (valid_o[1] !== 1'b1 || data_o[1] !== pa) begin
      fails++;
      $display("FAIL full_first: valid1=%b data=%h, expected 1 %h", valid_o[1], data_o[1], pa);
    end
    send(1, pb);
    for (int f = 0; f < 3; f++) begin
      tests++;
      if ({link_v_o, link_last_o, link_ready_o} !== 3'b101) begin
        fails++;
        $display("FAIL full_flit%0d: v=%b last=%b ready_o=%b, expected 1 0 1", f, link_v_o, link_last_o, link_ready_o);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({link_v_o, link_last_o, link_ready_o, link_data_o} !== {3'b110, pb[3*lw +: lw]}) begin
        fails++;
        $display("FAIL full_block%0d: v=%b last=%b ready_o=%b data=%h, expected 1 1 0 %h",
                 i, link_v_o, link_last_o, link_ready_o, link_data_o, pb[3*lw +: lw]);
      end
      tick();
    end
    rx_take(1);
    tick();
    tests++;
    if (link_ready_o !== 1'b1 || valid_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL full_release: ready_o=%b valid1=%b, expected 1 0", link_ready_o, valid_o[1]);
    end
    tick();
    tests++;
    if (valid_o[1] !== 1'b1 || data_o[1] !== pb || link_v_o !== 1'b0) begin
      fails++;
      $display("FAIL full_second: valid1=%b data=%h link_v=%b, expected 1 %h 0", valid_o[1], data_o[1], link_v_o, pb);
    end
    auto_yumi = 1'b1;
    drain(10);
  endtask

  task automatic test_reset_mid();
    send(0, 64'h1111_2222_3333_4444);
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    tests++;
    if (link_v_o !== 1'b0 || valid_o !== '0) begin
      fails++;
      $display("FAIL midreset_abort: link_v=%b valid_o=%b, expected 0 0", link_v_o, valid_o);
    end
    repeat (6) tick();
    tests++;
    if (valid_o !== '0) begin
      fails++;
      $display("FAIL midreset_partial: valid_o=%b, expected 0", valid_o);
    end
    send(3, 64'h5555_6666_7777_8888);
    drain(20);
  endtask

  task automatic test_width_40();
    logic [39:0] p = 40'hC3_89AB_4567;
    logic [15:0] ef [3] = '{16'h4567, 16'h89AB, 16'h00C3};
    tick();
    d40[1] = p;
    v40 = 2'b10;
    #1;
    tests++;
    if (y40 !== 2'b10) begin
      fails++;
      $display("FAIL w40_yumi: yumi=%b, expected 10", y40);
    end
    tick();
    v40 = '0;
    for (int f = 0; f < 3; f++) begin
      tests++;
      if ({l40_v, l40_last, l40_id, l40_data} !== {1'b1, (f == 2), 1'b1, ef[f]}) begin
        fails++;
        $display("FAIL w40_flit%0d: v=%b last=%b id=%0d data=%h, expected 1 %0b 1 %h",
                 f, l40_v, l40_last, l40_id, l40_data, (f == 2), ef[f]);
      end
      tick();
    end
    tests++;
    if (vo40[1] !== 1'b1 || do40[1] !== p) begin
      fails++;
      $display("FAIL w40_rx: valid=%b data=%h, expected 1 %h", vo40[1], do40[1], p);
    end
    yi40 = 2'b10;
    tick();
    yi40 = '0;
  endtask

  task automatic test_width_8();
    tick();
    d8[0] = 8'h5A;
    v8 = 2'b01;
    #1;
    tests++;
    if (y8 !== 2'b01) begin
      fails++;
      $display("FAIL w8_yumi: yumi=%b, expected 01", y8);
    end
    tick();
    v8 = '0;
    tests++;
    if ({l8_v, l8_last, l8_id, l8_data} !== {1'b1, 1'b1, 1'b0, 16'h005A}) begin
      fails++;
      $display("FAIL w8_flit: v=%b last=%b id=%0d data=%h, expected 1 1 0 005a", l8_v, l8_last, l8_id, l8_data);
    end
    tick();
    tests++;
    if (vo8 !== 2'b01 || do8[0] !== 8'h5A || l8_v !== 1'b0) begin
      fails++;
      $display("FAIL w8_rx: valid=%b data=%h link_v=%b, expected 01 5a 0", vo8, do8[0], l8_v);
    end
    yi8 = 2'b01;
    tick();
    yi8 = '0;
    tests++;
    if (vo8 !== 2'b00) begin
      fails++;
      $display("FAIL w8_clear: valid=%b, expected 00", vo8);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    auto_yumi = 1'b1;
    reset_i = 1'b1;
    tb_ready = 1'b1;
    valid_i = '0;
    data_i = '0;
    yumi_i = '0;
    v40 = '0; d40 = '0; yi40 = '0;
    v8 = '0;  d8 = '0;  yi8 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_full_slot();
    test_reset_mid();
    test_width_40();
    test_width_8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

endmodule
